// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use, taken-branch and memory-wait stall/flush
// generation, with memory-wait timeout flag and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
    input  logic                      dec_uses_rs,
    input  logic                      dec_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic                      exec_wb_reg,
    input  logic                      exec_mem_read,
    input  logic                      exec_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_stall,
    output logic                      fetch2dec_stall,
    output logic                      fetch2dec_flush,
    output logic                      dec2exec_stall,
    output logic                      dec2exec_flush,
    output logic                      exec2mem_stall,
    output logic                      mem_timeout,
    output logic [COUNT_WIDTH-1:0]    stall_count,
    output logic [COUNT_WIDTH-1:0]    flush_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] W_TMO = WCW'(MEM_TIMEOUT);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [WCW-1:0]         r_wait_cnt;
    logic [WCW-1:0]         w_wait_nxt;
    logic                   r_timeout;
    logic [COUNT_WIDTH-1:0] r_stall_cnt;
    logic [COUNT_WIDTH-1:0] r_flush_cnt;

    logic w_memwait;
    logic w_branch;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_loaduse;

    assign w_memwait = mem_req & ~mem_ready;
    assign w_branch  = exec_branch_taken & ~w_memwait;
    assign w_rs_hit  = dec_uses_rs & (dec_rs_addr == exec_rd_addr);
    assign w_rt_hit  = dec_uses_rt & (dec_rt_addr == exec_rd_addr);
    assign w_loaduse = exec_mem_read & exec_wb_reg
                     & (exec_rd_addr != '0) & (w_rs_hit | w_rt_hit);

    // First stalled cycle of a wait counts as 1; saturate at the timeout
    assign w_wait_nxt = (r_state == IDLE) ? WCW'(1)
                      : (r_wait_cnt == W_TMO) ? r_wait_cnt
                      : r_wait_cnt + WCW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: wait state mirrors an unfinished memory access
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_memwait) w_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready || !mem_req) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Mealy stall/flush outputs: memwait > branch > load-use
    always_comb begin
        pc_stall        = 1'b0;
        fetch2dec_stall = 1'b0;
        fetch2dec_flush = 1'b0;
        dec2exec_stall  = 1'b0;
        dec2exec_flush  = 1'b0;
        exec2mem_stall  = 1'b0;
        if (rst_n) begin
            if (w_memwait) begin
                pc_stall        = 1'b1;
                fetch2dec_stall = 1'b1;
                dec2exec_stall  = 1'b1;
                exec2mem_stall  = 1'b1;
            end else if (w_branch) begin
                fetch2dec_flush = 1'b1;
                dec2exec_flush  = 1'b1;
            end else if (w_loaduse) begin
                pc_stall        = 1'b1;
                fetch2dec_stall = 1'b1;
                dec2exec_flush  = 1'b1;
            end
        end
    end

    // Wait-duration tracking and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_memwait) begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == W_TMO) r_timeout <= 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_branch && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign mem_timeout = r_timeout;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 5;
    localparam int TMO = 4;
    localparam int CW  = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] dec_rs_addr, dec_rt_addr, exec_rd_addr;
    logic          dec_uses_rs, dec_uses_rt;
    logic          exec_wb_reg, exec_mem_read, exec_branch_taken;
    logic          mem_req, mem_ready;
    logic          pc_stall, fetch2dec_stall, fetch2dec_flush;
    logic          dec2exec_stall, dec2exec_flush, exec2mem_stall;
    logic          mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    int checks   = 0;
    int failures = 0;
    bit model_on = 0;

    // Behavioural model state
    int m_streak = 0;
    bit m_tmo    = 0;
    int m_sc     = 0;
    int m_fc     = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH(AW),
        .MEM_TIMEOUT(TMO),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .exec_rd_addr(exec_rd_addr), .exec_wb_reg(exec_wb_reg),
        .exec_mem_read(exec_mem_read),
        .exec_branch_taken(exec_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .fetch2dec_stall(fetch2dec_stall),
        .fetch2dec_flush(fetch2dec_flush),
        .dec2exec_stall(dec2exec_stall),
        .dec2exec_flush(dec2exec_flush),
        .exec2mem_stall(exec2mem_stall),
        .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Expected {pc, f2d_stall, f2d_flush, d2e_stall, d2e_flush, e2m_stall}
    function automatic logic [5:0] expect_outs();
        bit waiting, taken, hazard;
        if (!rst_n) return 6'b000000;
        waiting = mem_req && !mem_ready;
        taken   = exec_branch_taken && !waiting;
        hazard  = exec_mem_read && exec_wb_reg && exec_rd_addr != 0 &&
                  ((dec_uses_rs && dec_rs_addr == exec_rd_addr) ||
                   (dec_uses_rt && dec_rt_addr == exec_rd_addr));
        if (waiting) return 6'b110101;
        if (taken)   return 6'b001010;
        if (hazard)  return 6'b110010;
        return 6'b000000;
    endfunction

    // Model update on the clock edge from the inputs of the ending cycle
    always @(posedge clk) begin
        logic [5:0] e;
        e = expect_outs();
        if (!rst_n) begin
            m_streak = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (mem_req && !mem_ready) m_streak = m_streak + 1;
            else                       m_streak = 0;
            if (m_streak >= TMO) m_tmo = 1;
            if (e[5]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (exec_branch_taken && !(mem_req && !mem_ready))
                m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [5:0] e;
        if (model_on) begin
            e = expect_outs();
            chk("pc_stall", pc_stall, e[5]);
            chk("fetch2dec_stall", fetch2dec_stall, e[4]);
            chk("fetch2dec_flush", fetch2dec_flush, e[3]);
            chk("dec2exec_stall", dec2exec_stall, e[2]);
            chk("dec2exec_flush", dec2exec_flush, e[1]);
            chk("exec2mem_stall", exec2mem_stall, e[0]);
            chk("mem_timeout", mem_timeout, m_tmo);
            chk("stall_count", stall_count, m_sc);
            chk("flush_count", flush_count, m_fc);
        end
    end

    task automatic drive(input bit rn, input int rs, input bit urs,
                         input int rd, input bit wb, input bit ld,
                         input bit bt, input bit mq, input bit mr);
        @(posedge clk);
        #1;
        rst_n             = rn;
        dec_rs_addr       = AW'(rs);
        dec_rt_addr       = AW'(31);
        dec_uses_rs       = urs;
        dec_uses_rt       = 1'b0;
        exec_rd_addr      = AW'(rd);
        exec_wb_reg       = wb;
        exec_mem_read     = ld;
        exec_branch_taken = bt;
        mem_req           = mq;
        mem_ready         = mr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        dec_rs_addr = '0; dec_rt_addr = '0; exec_rd_addr = '0;
        dec_uses_rs = 0; dec_uses_rt = 0; exec_wb_reg = 0;
        exec_mem_read = 0; exec_branch_taken = 0;
        mem_req = 0; mem_ready = 0;

        // Reset with a load-use pattern present: outputs forced low
        drive(0, 5, 1, 5, 1, 1, 0, 0, 0);
        model_on = 1;
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_d2e_flush", dec2exec_flush, 0);
        idle();
        chk("rst_stall_count", stall_count, 0);
        chk("rst_timeout", mem_timeout, 0);

        // Load-use on rs=5
        drive(1, 5, 1, 5, 1, 1, 0, 0, 0);
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_f2d_stall", fetch2dec_stall, 1);
        chk("lu_d2e_flush", dec2exec_flush, 1);
        chk("lu_d2e_stall", dec2exec_stall, 0);
        idle();
        chk("lu_pc_release", pc_stall, 0);
        chk("lu_stall_count", stall_count, 1);

        // rd=0 never hazards
        drive(1, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("r0_pc_stall", pc_stall, 0);

        // Branch overrides a coincident load-use
        drive(1, 5, 1, 5, 1, 1, 1, 0, 0);
        chk("br_f2d_flush", fetch2dec_flush, 1);
        chk("br_d2e_flush", dec2exec_flush, 1);
        chk("br_pc_stall", pc_stall, 0);
        idle();
        chk("br_flush_count", flush_count, 1);

        // 3-cycle memory wait with a branch held in execute
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
            chk("mw_e2m_stall", exec2mem_stall, 1);
            chk("mw_f2d_flush", fetch2dec_flush, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("mw_done_stall", pc_stall, 0);
        chk("mw_done_f2d_flush", fetch2dec_flush, 1);
        chk("mw_done_d2e_flush", dec2exec_flush, 1);
        idle();
        chk("mw_stall_count", stall_count, 4);
        chk("mw_flush_count", flush_count, 2);
        chk("mw_no_timeout", mem_timeout, 0);

        // 6-cycle wait against a timeout of 4
        for (int k = 1; k <= 6; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("to_stall", dec2exec_stall, 1);
            if (k == 4) chk("to_not_yet", mem_timeout, 0);
            if (k == 5) chk("to_raised", mem_timeout, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("to_release", pc_stall, 0);
        idle();
        chk("to_sticky", mem_timeout, 1);
        chk("to_stall_count", stall_count, 10);

        // Reset in the middle of a wait
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rmw_e2m_stall", exec2mem_stall, 0);
        chk("rmw_pc_stall", pc_stall, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("rmw_zero_wait", pc_stall, 0);
        chk("rmw_stall_count", stall_count, 0);
        chk("rmw_flush_count", flush_count, 0);
        chk("rmw_timeout", mem_timeout, 0);

        // Randomized traffic, small address space for frequent matches
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n             = ($urandom_range(0, 599) != 0);
            dec_rs_addr       = AW'($urandom_range(0, 3));
            dec_rt_addr       = AW'($urandom_range(0, 3));
            dec_uses_rs       = 1'($urandom_range(0, 1));
            dec_uses_rt       = 1'($urandom_range(0, 1));
            exec_rd_addr      = AW'($urandom_range(0, 3));
            exec_wb_reg       = ($urandom_range(0, 3) != 0);
            exec_mem_read     = 1'($urandom_range(0, 1));
            exec_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req           = 1'($urandom_range(0, 1));
            mem_ready         = ($urandom_range(0, 9) < 4);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
